// File: rtl/muldiv_ctrl_pkg.sv
// Shared types for the MULT/MULTU/DIV/DIVU sequencer: operation codes and FSM states.
package muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4
    } MulDivOpType;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_RUN  = 2'd2,
        DONE     = 2'd3
    } MulDivStateType;

    function automatic logic op_is_div(input MulDivOpType op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input MulDivOpType op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/div_radix2_core.sv
// Restoring unsigned radix-2 divider: start loads operands, each step retires one quotient bit.
module div_radix2_core #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    logic [W-1:0] rem_q;
    logic [W-1:0] quo_q;
    logic [W-1:0] div_q;
    logic [W:0]   partial;
    logic [W:0]   trial;

    // quo_q doubles as the dividend shift register; quotient bits enter at the LSB.
    assign partial = {rem_q, quo_q[W-1]};
    assign trial   = partial - {1'b0, div_q};

    always_ff @(posedge clk) begin
        if (!rst) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            div_q <= divisor;
        end else if (step) begin
            if (!trial[W]) begin
                rem_q <= trial[W-1:0];
                quo_q <= {quo_q[W-2:0], 1'b1};
            end else begin
                rem_q <= partial[W-1:0];
                quo_q <= {quo_q[W-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer beside the EXE ALU, producing a one-beat HI/LO write.
// Optional MULDIV_DIVZERO_BYPASS_EN: divide-by-zero skips the iterations and completes immediately.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = 2,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        EXE_MulDivOp,
    input  logic [DATA_W-1:0] EXE_BusA,
    input  logic [DATA_W-1:0] EXE_BusB,
    input  logic              EXEMEM_Flush,
    input  logic              MEM_Stall,
    output logic              MD_Stall,
    output logic              MD_HIWr,
    output logic              MD_LOWr,
    output logic [DATA_W-1:0] MD_HI,
    output logic [DATA_W-1:0] MD_LO,
    output logic [1:0]        dbg_state
);

    localparam int CNT_MAX = (DATA_W > MUL_LATENCY) ? DATA_W : MUL_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int PW      = 2 * DATA_W;

    MulDivOpType    op;
    MulDivStateType state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic              op_valid, op_div, op_sgn, a_neg, b_neg, b_zero, issue;
    logic [DATA_W-1:0] a_mag_in, b_mag_in;
    logic              div_start, div_step, done_beat;

    logic              is_div_q, sign_a_q, sign_b_q, divzero_q;
    logic [DATA_W-1:0] a_mag_q, b_mag_q, a_raw_q;
    logic [DATA_W-1:0] hi_q, lo_q;
    logic [PW-1:0]     prod_pipe [MUL_LATENCY];

    logic [DATA_W-1:0] core_q, core_r, q_fix, r_fix, hi_res, lo_res;
    logic [PW-1:0]     prod_mag, prod_fix;

    assign op       = MulDivOpType'(EXE_MulDivOp);
    assign op_valid = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    assign op_div   = op_is_div(op);
    assign op_sgn   = op_is_signed(op);
    assign a_neg    = op_sgn & EXE_BusA[DATA_W-1];
    assign b_neg    = op_sgn & EXE_BusB[DATA_W-1];
    assign a_mag_in = a_neg ? -EXE_BusA : EXE_BusA;
    assign b_mag_in = b_neg ? -EXE_BusB : EXE_BusB;
    assign b_zero   = (EXE_BusB == '0);
    assign issue    = (state == IDLE) && op_valid && !EXEMEM_Flush;

    // Handshake: MD_Stall freezes the front end while an op is accepted or running; the DONE
    // cycle presents the result with HIWr/LOWr high and repeats it while MEM_Stall holds.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        MD_Stall  = 1'b0;
        div_start = 1'b0;
        div_step  = 1'b0;
        done_beat = 1'b0;
        case (state)
            IDLE: begin
                MD_Stall = op_valid;
                if (issue) begin
                    if (op_div) begin
`ifdef MULDIV_DIVZERO_BYPASS_EN
                        if (b_zero) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt = DIV_RUN;
                            cnt_nxt   = CNT_W'(DATA_W - 1);
                            div_start = 1'b1;
                        end
`else
                        state_nxt = DIV_RUN;
                        cnt_nxt   = CNT_W'(DATA_W - 1);
                        div_start = 1'b1;
`endif
                    end else begin
                        state_nxt = MUL_WAIT;
                        cnt_nxt   = CNT_W'(MUL_LATENCY - 1);
                    end
                end
            end
            MUL_WAIT: begin
                MD_Stall = 1'b1;
                if (cnt == '0) state_nxt = DONE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            DIV_RUN: begin
                MD_Stall = 1'b1;
                div_step = 1'b1;
                if (cnt == '0) state_nxt = DONE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            DONE: begin
                done_beat = !EXEMEM_Flush;
                if (!MEM_Stall) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A flush wins over everything, including a DONE beat in the same cycle.
        if (EXEMEM_Flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            is_div_q  <= 1'b0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            divzero_q <= 1'b0;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            a_raw_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (issue) begin
                is_div_q  <= op_div;
                sign_a_q  <= a_neg;
                sign_b_q  <= b_neg;
                divzero_q <= op_div & b_zero;
                a_mag_q   <= a_mag_in;
                b_mag_q   <= b_mag_in;
                a_raw_q   <= EXE_BusA;
            end
            if (done_beat) begin
                hi_q <= hi_res;
                lo_q <= lo_res;
            end
        end
    end

    // Product emerges from the last stage exactly when the counter lands the FSM in DONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < MUL_LATENCY; i++) prod_pipe[i] <= '0;
        end else begin
            prod_pipe[0] <= PW'(a_mag_q) * PW'(b_mag_q);
            for (int i = 1; i < MUL_LATENCY; i++) prod_pipe[i] <= prod_pipe[i-1];
        end
    end

    div_radix2_core #(.W(DATA_W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .step      (div_step),
        .dividend  (a_mag_in),
        .divisor   (b_mag_in),
        .quotient  (core_q),
        .remainder (core_r)
    );

    // Divide-by-zero reports all-ones quotient and the untouched dividend as remainder.
    assign prod_mag = prod_pipe[MUL_LATENCY-1];
    assign prod_fix = (sign_a_q ^ sign_b_q) ? -prod_mag : prod_mag;
    assign q_fix    = divzero_q ? '1 : ((sign_a_q ^ sign_b_q) ? -core_q : core_q);
    assign r_fix    = divzero_q ? a_raw_q : (sign_a_q ? -core_r : core_r);
    assign hi_res   = is_div_q ? r_fix : prod_fix[PW-1:DATA_W];
    assign lo_res   = is_div_q ? q_fix : prod_fix[DATA_W-1:0];

    assign MD_HIWr   = done_beat;
    assign MD_LOWr   = done_beat;
    assign MD_HI     = done_beat ? hi_res : hi_q;
    assign MD_LO     = done_beat ? lo_res : lo_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed table-driven bench for muldiv_ctrl plus hand sequences for flush, reset and MEM_Stall.
module tb_muldiv_ctrl;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam int MUL_STALL = 3;
    localparam int DIV_STALL = 33;
`ifdef MULDIV_DIVZERO_BYPASS_EN
    localparam int DZ_STALL = 1;
`else
    localparam int DZ_STALL = 33;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          exp_stall;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  op = OP_NONE;
    logic [31:0] bus_a = '0;
    logic [31:0] bus_b = '0;
    logic        flush = 1'b0;
    logic        mem_stall = 1'b0;
    logic        md_stall, md_hiwr, md_lowr;
    logic [31:0] md_hi, md_lo;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    vec_t vecs[12];

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_LATENCY(2), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .EXE_MulDivOp (op),
        .EXE_BusA     (bus_a),
        .EXE_BusB     (bus_b),
        .EXEMEM_Flush (flush),
        .MEM_Stall    (mem_stall),
        .MD_Stall     (md_stall),
        .MD_HIWr      (md_hiwr),
        .MD_LOWr      (md_lowr),
        .MD_HI        (md_hi),
        .MD_LO        (md_lo),
        .dbg_state    (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents one op at the next negedge, counts stall cycles, then checks the DONE beat(s).
    task automatic run_op(input vec_t v, input int mem_hold, input string tag);
        int   stalls = 0;
        bit   done = 0;
        logic [63:0] exp;
        @(negedge clk);
        op = v.op;
        bus_a = v.a;
        bus_b = v.b;
        mem_stall = (mem_hold > 0);
        exp_q.push_back({v.exp_hi, v.exp_lo});
        for (int c = 0; c < 100 && !done; c++) begin
            #1;
            if (md_hiwr) done = 1;
            else begin
                if (md_stall) stalls++;
                @(negedge clk);
            end
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        exp = exp_q.pop_front();
        if (!done) begin
            op = OP_NONE;
            mem_stall = 1'b0;
            return;
        end
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(v.exp_stall));
        for (int k = 0; k <= mem_hold; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (k == mem_hold) mem_stall = 1'b0;
                #1;
            end
            check($sformatf("%s_hiwr%0d", tag, k), 32'(md_hiwr), 32'd1);
            check($sformatf("%s_lowr%0d", tag, k), 32'(md_lowr), 32'd1);
            check($sformatf("%s_nostall%0d", tag, k), 32'(md_stall), 32'd0);
            check($sformatf("%s_hi%0d", tag, k), md_hi, exp[63:32]);
            check($sformatf("%s_lo%0d", tag, k), md_lo, exp[31:0]);
        end
    endtask

    task automatic post_check(input vec_t v, input string tag);
        @(negedge clk);
        op = OP_NONE;
        bus_a = '0;
        bus_b = '0;
        #1;
        check({tag, "_post_hiwr"}, 32'(md_hiwr), 32'd0);
        check({tag, "_post_lowr"}, 32'(md_lowr), 32'd0);
        check({tag, "_post_stall"}, 32'(md_stall), 32'd0);
        check({tag, "_hold_hi"}, md_hi, v.exp_hi);
        check({tag, "_hold_lo"}, md_lo, v.exp_lo);
    endtask

    initial begin
        vec_t v;
        int   stray;

        vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,        MUL_STALL, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,        MUL_STALL, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, MUL_STALL, 32'h4000_0000, 32'h0000_0000};
        vecs[3]  = '{OP_MULT,  32'd7,        32'hFFFF_FFFF, MUL_STALL, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
        vecs[4]  = '{OP_DIVU,  32'd100,      32'd7,        DIV_STALL, 32'd2,         32'd14};
        vecs[5]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        DIV_STALL, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[6]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, DIV_STALL, 32'h0000_0000, 32'h8000_0000};
        vecs[7]  = '{OP_DIVU,  32'h0000_1234, 32'd0,        DZ_STALL,  32'h0000_1234, 32'hFFFF_FFFF};
        vecs[8]  = '{OP_DIV,   32'd7,        32'hFFFF_FFFE, DIV_STALL, 32'd1,         32'hFFFF_FFFD};
        vecs[9]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,        DIV_STALL, 32'd0,         32'hFFFF_FFFF};
        vecs[10] = '{OP_DIV,   32'hFFFF_FF9C, 32'hFFFF_FFF9, DIV_STALL, 32'hFFFF_FFFE, 32'd14};
        vecs[11] = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,        DZ_STALL,  32'hFFFF_FFFB, 32'hFFFF_FFFF};

        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_stall", 32'(md_stall), 32'd0);
        check("rst_hiwr", 32'(md_hiwr), 32'd0);
        check("rst_lowr", 32'(md_lowr), 32'd0);
        check("rst_hi", md_hi, 32'd0);
        check("rst_lo", md_lo, 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i], 0, $sformatf("v%0d", i));
            post_check(vecs[i], $sformatf("v%0d", i));
        end

        // DONE held by MEM_Stall for 3 cycles, then MULTU issued the cycle after DONE exit.
        run_op(vecs[4], 3, "memstall");
        v = '{OP_MULTU, 32'd6, 32'd7, MUL_STALL, 32'd0, 32'd42};
        run_op(v, 0, "b2b");
        post_check(v, "b2b");

        // Flush at DIV iteration 10.
        @(negedge clk);
        op = OP_DIV;
        bus_a = 32'hFFFF_FFF9;
        bus_b = 32'd2;
        #1;
        check("flush_issue_stall", 32'(md_stall), 32'd1);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        op = OP_NONE;
        #1;
        check("flush_cycle_hiwr", 32'(md_hiwr), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_state", 32'(dbg_state), 32'd0);
        check("flush_stall", 32'(md_stall), 32'd0);
        check("flush_hi_hold", md_hi, 32'd0);
        check("flush_lo_hold", md_lo, 32'd42);
        stray = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (md_hiwr || md_lowr) stray++;
        end
        check("flush_no_write", 32'(stray), 32'd0);

        // Reset at DIV iteration 20.
        @(negedge clk);
        op = OP_DIVU;
        bus_a = 32'd100;
        bus_b = 32'd7;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        op = OP_NONE;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_state", 32'(dbg_state), 32'd0);
        check("midrst_stall", 32'(md_stall), 32'd0);
        check("midrst_hiwr", 32'(md_hiwr), 32'd0);
        check("midrst_hi", md_hi, 32'd0);
        check("midrst_lo", md_lo, 32'd0);

        // Flush arriving in the DONE cycle suppresses the write.
        @(negedge clk);
        op = OP_MULTU;
        bus_a = 32'd3;
        bus_b = 32'd3;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        op = OP_NONE;
        #1;
        check("doneflush_state", 32'(dbg_state), 32'd3);
        check("doneflush_hiwr", 32'(md_hiwr), 32'd0);
        check("doneflush_lowr", 32'(md_lowr), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("doneflush_idle", 32'(dbg_state), 32'd0);
        check("doneflush_lo_hold", md_lo, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
